jtag_tap_bsr: RTL and testbench
===============================

JTAG_TAP_BSR -- requirements
Module: jtag_tap_bsr

Interface
REQ-001 Parameter IR_W, default 4: instruction register width, at least 2.
REQ-002 Parameter BSR_W, default 8: boundary-scan chain length, at least 1.
REQ-003 Parameter IDCODE_VAL, default 32'h03631093: device ID; bit 0 SHALL be 1.
REQ-004 Ports SHALL be:
- tck  in  1  sole clock; all flops use the posedge.
- rst_n  in  1  asynchronous active-low reset.
- tms  in  1  mode select.
- tdi  in  1  serial in.
- tdo  out  1  serial out.
- tdo_en  out  1  high only in Shift-IR/Shift-DR.
- core_in  in  BSR_W  functional pin values from the core.
- pad_in  in  BSR_W  pad-side values.
- pad_out  out  BSR_W  values to pads.
- core_out  out  BSR_W  values to the core.
- instr  out  IR_W  active instruction.
- tlr  out  1  high in Test-Logic-Reset.

Function
REQ-005 FSM SHALL implement all 16 IEEE 1149.1 TAP states with standard TMS transitions, one transition per tck posedge.
REQ-006 Five consecutive TMS=1 SHALL reach Test-Logic-Reset from any state; no separate counter is used.
REQ-007 Capture-IR SHALL load the IR shift register with {IR_W-2 zeros, 2'b01}.
REQ-008 In Shift-IR/Shift-DR, each posedge SHALL shift right: tdi enters the MSB, and tdo shows the LSB combinationally.
REQ-009 Update-IR SHALL copy the shift register to instr.
REQ-010 Test-Logic-Reset SHALL force instr to IDCODE (see REQ-020).
REQ-011 Opcodes SHALL be:
- EXTEST = 0
- IDCODE = 1
- SAMPLE_PRELOAD = 2
- INTEST = 3
- BYPASS = all ones
- any other value SHALL decode as BYPASS.
REQ-012 BYPASS selects a 1-bit register that SHALL capture 0 in Capture-DR, giving a one-cycle tdi-to-tdo delay.
REQ-013 IDCODE selects a 32-bit register that SHALL capture IDCODE_VAL.
REQ-014 For SAMPLE_PRELOAD and EXTEST, the BSR shift register SHALL capture core_in in Capture-DR.
REQ-015 For INTEST, the BSR shift register SHALL capture pad_in in Capture-DR.
REQ-016 Update-DR SHALL copy the BSR shift register into the BSR update register, only when a BSR instruction is active.
REQ-017 pad_out SHALL equal the BSR update register under EXTEST, otherwise core_in.
REQ-018 core_out SHALL equal the BSR update register under INTEST, otherwise pad_in.
REQ-019 Pause-IR/Pause-DR SHALL hold all shift registers; Exit2 back to Shift SHALL resume without bit loss.

Reset
REQ-020 rst_n low SHALL asynchronously set:
- state = Test-Logic-Reset, tlr=1, tdo_en=0
- instr = IDCODE, or BYPASS if the IDCODE feature is compiled out
- IR shift register = 0, BSR shift and update registers = 0, bypass = 0
REQ-021 Entering Test-Logic-Reset via TMS SHALL produce the same values as REQ-020, except the BSR update register, which holds.
REQ-022 Reset during a shift SHALL abort it; the update register SHALL remain unchanged.

Configuration
REQ-023 Macro JTAG_TAP_IDCODE_EN defined: the IDCODE register and opcode exist, and the reset instruction is IDCODE.
REQ-024 Macro JTAG_TAP_IDCODE_EN undefined: no IDCODE register, opcode 1 decodes as BYPASS, and the reset instruction is BYPASS.

Structure
REQ-025 Package jtag_tap_pkg SHALL hold the tap_state_e enum (16 states) and the opcode constants.
REQ-026 Sub-module jtag_tap_fsm SHALL contain the state register and the next-state logic.
REQ-027 jtag_tap_fsm SHALL output one-hot capture/shift/update strobes for IR and DR, plus tlr.

Verification
REQ-028 From Shift-DR, TMS=1 for 5 tck -> Test-Logic-Reset; tlr=1, instr=IDCODE.
REQ-029 After reset, Shift-DR 32 cycles -> tdo reads 32'h03631093, LSB first.
REQ-030 Load IR=all ones, shift 8'hA5 through DR -> tdo returns A5 delayed by one tck.
REQ-031 Shift-IR with BSR_W=8 -> first two tdo bits read 1,0 (capture pattern 01, LSB first).
REQ-032 SAMPLE_PRELOAD with core_in=8'h3C, shift 8 cycles -> tdo reads 8'h3C, LSB first.
REQ-033 PRELOAD 8'hF0, then EXTEST -> pad_out=8'hF0 after Update-DR; back to BYPASS -> pad_out follows core_in.

Source files
------------

// File: rtl/jtag_tap_pkg.sv
// Shared types and constants for the JTAG TAP with boundary-scan register.
//   tap_state_e  : the sixteen TAP controller states
//   tap_strobe_t : per-state action strobes produced by the TAP FSM
//   Op*          : instruction opcodes (BYPASS is all ones at the IR width in use)
package jtag_tap_pkg;

   typedef enum logic [3:0] {
      StTestLogicReset,
      StRunTestIdle,
      StSelectDrScan,
      StCaptureDr,
      StShiftDr,
      StExit1Dr,
      StPauseDr,
      StExit2Dr,
      StUpdateDr,
      StSelectIrScan,
      StCaptureIr,
      StShiftIr,
      StExit1Ir,
      StPauseIr,
      StExit2Ir,
      StUpdateIr
   } tap_state_e;

   // At most one field is set at any time.
   typedef struct packed {
      logic capture_ir;
      logic shift_ir;
      logic update_ir;
      logic capture_dr;
      logic shift_dr;
      logic update_dr;
   } tap_strobe_t;

   localparam int unsigned OpExtest        = 0;
   localparam int unsigned OpIdcode        = 1;
   localparam int unsigned OpSamplePreload = 2;
   localparam int unsigned OpIntest        = 3;

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP controller: state register plus next-state logic.
// Ports:
//   i_tck   : test clock, all state changes on its rising edge
//   i_rst_n : asynchronous active-low reset to Test-Logic-Reset
//   i_tms   : mode select
//   o_strb  : capture/shift/update strobes for IR and DR (decoded from current state)
//   o_tlr   : high while in Test-Logic-Reset
module jtag_tap_fsm
   import jtag_tap_pkg::*;
(
   input  logic        i_tck,
   input  logic        i_rst_n,
   input  logic        i_tms,
   output tap_strobe_t o_strb,
   output logic        o_tlr
);

   tap_state_e r_state;
   tap_state_e w_state_next;

   always_ff @(posedge i_tck or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= StTestLogicReset;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Every state reaches Test-Logic-Reset within five TMS=1 edges.
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StTestLogicReset: w_state_next = i_tms ? StTestLogicReset : StRunTestIdle;
         StRunTestIdle:    w_state_next = i_tms ? StSelectDrScan   : StRunTestIdle;
         StSelectDrScan:   w_state_next = i_tms ? StSelectIrScan   : StCaptureDr;
         StCaptureDr:      w_state_next = i_tms ? StExit1Dr        : StShiftDr;
         StShiftDr:        w_state_next = i_tms ? StExit1Dr        : StShiftDr;
         StExit1Dr:        w_state_next = i_tms ? StUpdateDr       : StPauseDr;
         StPauseDr:        w_state_next = i_tms ? StExit2Dr        : StPauseDr;
         StExit2Dr:        w_state_next = i_tms ? StUpdateDr       : StShiftDr;
         StUpdateDr:       w_state_next = i_tms ? StSelectDrScan   : StRunTestIdle;
         StSelectIrScan:   w_state_next = i_tms ? StTestLogicReset : StCaptureIr;
         StCaptureIr:      w_state_next = i_tms ? StExit1Ir        : StShiftIr;
         StShiftIr:        w_state_next = i_tms ? StExit1Ir        : StShiftIr;
         StExit1Ir:        w_state_next = i_tms ? StUpdateIr       : StPauseIr;
         StPauseIr:        w_state_next = i_tms ? StExit2Ir        : StPauseIr;
         StExit2Ir:        w_state_next = i_tms ? StUpdateIr       : StShiftIr;
         StUpdateIr:       w_state_next = i_tms ? StSelectDrScan   : StRunTestIdle;
         default:          w_state_next = StTestLogicReset;
      endcase
   end

   always_comb begin
      o_strb            = '0;
      o_strb.capture_ir = (r_state == StCaptureIr);
      o_strb.shift_ir   = (r_state == StShiftIr);
      o_strb.update_ir  = (r_state == StUpdateIr);
      o_strb.capture_dr = (r_state == StCaptureDr);
      o_strb.shift_dr   = (r_state == StShiftDr);
      o_strb.update_dr  = (r_state == StUpdateDr);
      o_tlr             = (r_state == StTestLogicReset);
   end

endmodule

// File: rtl/jtag_tap_bsr.sv
// JTAG TAP with instruction register, bypass, optional IDCODE and a boundary-scan register.
// Optional feature: define JTAG_TAP_IDCODE_EN to include the 32-bit IDCODE register and opcode;
// without it opcode 1 decodes as BYPASS and BYPASS is the reset instruction.
// Ports:
//   tck, rst_n        : test clock (rising edge) and asynchronous active-low reset
//   tms, tdi, tdo     : TAP mode select, serial in, serial out (LSB of the active shift register)
//   tdo_en            : high only in Shift-IR / Shift-DR
//   core_in, pad_in   : functional values from the core and from the pads
//   pad_out, core_out : values driven to the pads and to the core
//   instr             : active instruction
//   tlr               : high in Test-Logic-Reset
module jtag_tap_bsr
   import jtag_tap_pkg::*;
#(
   parameter int unsigned IR_W       = 4,
   parameter int unsigned BSR_W      = 8,
   parameter logic [31:0] IDCODE_VAL = 32'h03631093
) (
   input  logic             tck,
   input  logic             rst_n,
   input  logic             tms,
   input  logic             tdi,
   output logic             tdo,
   output logic             tdo_en,
   input  logic [BSR_W-1:0] core_in,
   input  logic [BSR_W-1:0] pad_in,
   output logic [BSR_W-1:0] pad_out,
   output logic [BSR_W-1:0] core_out,
   output logic [IR_W-1:0]  instr,
   output logic             tlr
);

   localparam logic [IR_W-1:0] OpBypass = '1;
`ifdef JTAG_TAP_IDCODE_EN
   localparam logic [IR_W-1:0] ResetInstr = IR_W'(OpIdcode);
`else
   localparam logic [IR_W-1:0] ResetInstr = OpBypass;
`endif

   tap_strobe_t w_strb;
   logic        w_tlr;

   jtag_tap_fsm u_fsm (
      .i_tck   (tck),
      .i_rst_n (rst_n),
      .i_tms   (tms),
      .o_strb  (w_strb),
      .o_tlr   (w_tlr)
   );

   assign tlr    = w_tlr;
   assign tdo_en = w_strb.shift_ir | w_strb.shift_dr;

   // ---------------- Instruction register ----------------
   logic [IR_W-1:0] r_ir_sr;
   logic [IR_W-1:0] r_instr;
   logic [IR_W:0]   w_ir_shift;

   assign w_ir_shift = {tdi, r_ir_sr};

   always_ff @(posedge tck or negedge rst_n) begin
      if (!rst_n) begin
         r_ir_sr <= '0;
         r_instr <= ResetInstr;
      end else if (w_tlr) begin
         r_ir_sr <= '0;
         r_instr <= ResetInstr;
      end else begin
         if (w_strb.capture_ir) begin
            r_ir_sr <= IR_W'(1);
         end else if (w_strb.shift_ir) begin
            r_ir_sr <= w_ir_shift[IR_W:1];
         end
         if (w_strb.update_ir) begin
            r_instr <= r_ir_sr;
         end
      end
   end

   // Forcing here makes the reset instruction visible on the same edge that enters TLR.
   assign instr = w_tlr ? ResetInstr : r_instr;

   // ---------------- Instruction decode ----------------
   logic w_is_extest;
   logic w_is_intest;
   logic w_sel_bsr;
   logic w_sel_idcode;
   logic w_idcode_tdo;

   assign w_is_extest = (instr == IR_W'(OpExtest));
   assign w_is_intest = (instr == IR_W'(OpIntest));
   assign w_sel_bsr   = w_is_extest | w_is_intest | (instr == IR_W'(OpSamplePreload));

   // ---------------- Bypass register ----------------
   logic r_bypass;

   always_ff @(posedge tck or negedge rst_n) begin
      if (!rst_n) begin
         r_bypass <= 1'b0;
      end else if (w_tlr || w_strb.capture_dr) begin
         r_bypass <= 1'b0;
      end else if (w_strb.shift_dr) begin
         r_bypass <= tdi;
      end
   end

   // ---------------- IDCODE register ----------------
`ifdef JTAG_TAP_IDCODE_EN
   logic [31:0] r_idcode_sr;

   assign w_sel_idcode = (instr == IR_W'(OpIdcode));
   assign w_idcode_tdo = r_idcode_sr[0];

   always_ff @(posedge tck or negedge rst_n) begin
      if (!rst_n) begin
         r_idcode_sr <= '0;
      end else if (w_strb.capture_dr && w_sel_idcode) begin
         r_idcode_sr <= IDCODE_VAL;
      end else if (w_strb.shift_dr && w_sel_idcode) begin
         r_idcode_sr <= {tdi, r_idcode_sr[31:1]};
      end
   end
`else
   logic w_unused_idcode;

   assign w_sel_idcode    = 1'b0;
   assign w_idcode_tdo    = 1'b0;
   // The ID value is a parameter of the interface even when its register is absent.
   assign w_unused_idcode = ^IDCODE_VAL;
`endif

   // ---------------- Boundary-scan register ----------------
   logic [BSR_W-1:0] r_bsr_sr;
   logic [BSR_W-1:0] r_bsr_upd;
   logic [BSR_W:0]   w_bsr_shift;

   assign w_bsr_shift = {tdi, r_bsr_sr};

   // The update stage is cleared only by rst_n; TLR entered through TMS leaves it alone.
   always_ff @(posedge tck or negedge rst_n) begin
      if (!rst_n) begin
         r_bsr_sr  <= '0;
         r_bsr_upd <= '0;
      end else begin
         if (w_tlr) begin
            r_bsr_sr <= '0;
         end else if (w_strb.capture_dr && w_sel_bsr) begin
            r_bsr_sr <= w_is_intest ? pad_in : core_in;
         end else if (w_strb.shift_dr && w_sel_bsr) begin
            r_bsr_sr <= w_bsr_shift[BSR_W:1];
         end
         if (w_strb.update_dr && w_sel_bsr) begin
            r_bsr_upd <= r_bsr_sr;
         end
      end
   end

   assign pad_out  = w_is_extest ? r_bsr_upd : core_in;
   assign core_out = w_is_intest ? r_bsr_upd : pad_in;

   // ---------------- TDO mux ----------------
   always_comb begin
      tdo = 1'b0;
      if (w_strb.shift_ir) begin
         tdo = r_ir_sr[0];
      end else if (w_strb.shift_dr) begin
         if (w_sel_bsr) begin
            tdo = r_bsr_sr[0];
         end else if (w_sel_idcode) begin
            tdo = w_idcode_tdo;
         end else begin
            tdo = r_bypass;
         end
      end
   end

endmodule

// File: tb/tb_jtag_tap_bsr.sv
// Self-checking bench for jtag_tap_bsr (default parameters). Follows JTAG_TAP_IDCODE_EN
// for the expected reset instruction and IDCODE behaviour.
module tb_jtag_tap_bsr;

   localparam int unsigned IrW   = 4;
   localparam int unsigned BsrW  = 8;
   localparam logic [31:0] IdVal = 32'h03631093;
`ifdef JTAG_TAP_IDCODE_EN
   localparam logic [IrW-1:0] ResetInstr = 4'h1;
`else
   localparam logic [IrW-1:0] ResetInstr = 4'hF;
`endif

   logic            tck = 1'b0;
   logic            rst_n;
   logic            tms;
   logic            tdi;
   logic            tdo;
   logic            tdo_en;
   logic [BsrW-1:0] core_in;
   logic [BsrW-1:0] pad_in;
   logic [BsrW-1:0] pad_out;
   logic [BsrW-1:0] core_out;
   logic [IrW-1:0]  instr;
   logic            tlr;

   jtag_tap_bsr #(
      .IR_W       (IrW),
      .BSR_W      (BsrW),
      .IDCODE_VAL (IdVal)
   ) dut (
      .tck      (tck),
      .rst_n    (rst_n),
      .tms      (tms),
      .tdi      (tdi),
      .tdo      (tdo),
      .tdo_en   (tdo_en),
      .core_in  (core_in),
      .pad_in   (pad_in),
      .pad_out  (pad_out),
      .core_out (core_out),
      .instr    (instr),
      .tlr      (tlr)
   );

   always #5 tck = ~tck;

   int n_checks = 0;
   int n_errors = 0;

   logic [63:0] exp_q[$];
   string       name_q[$];

   typedef struct {
      logic [IrW-1:0]  op;
      logic [BsrW-1:0] core;
      logic [BsrW-1:0] pad;
      logic [63:0]     din;
      int              n;
      logic [63:0]     tdo_w;
      logic [BsrW-1:0] pad_o;
      logic [BsrW-1:0] core_o;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic sb_push(input string name, input logic [63:0] exp);
      exp_q.push_back(exp);
      name_q.push_back(name);
   endtask

   task automatic sb_pop(input logic [63:0] act);
      if (exp_q.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL scoreboard_empty: got %0h, expected nothing pending", act);
      end else begin
         check(name_q.pop_front(), act, exp_q.pop_front());
      end
   endtask

   // One TCK: drive tms/tdi, wait for the rising edge, settle 1 time unit.
   task automatic tick(input logic t, input logic d);
      tms = t;
      tdi = d;
      @(posedge tck);
      #1;
   endtask

   // From Run-Test/Idle: full DR scan of n bits, ending back in Run-Test/Idle.
   task automatic scan_dr(input logic [63:0] din, input int n, output logic [63:0] dout,
                          output logic en_ok);
      dout  = '0;
      en_ok = 1'b1;
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      for (int i = 0; i < n; i++) begin
         if (tdo_en !== 1'b1) en_ok = 1'b0;
         dout[i] = tdo;
         tick(i == n - 1, din[i]);
      end
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
   endtask

   // From Run-Test/Idle: load an opcode, return the captured IR bits seen on tdo.
   task automatic scan_ir(input logic [IrW-1:0] op, output logic [63:0] dout,
                          output logic en_ok);
      dout  = '0;
      en_ok = 1'b1;
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      for (int i = 0; i < int'(IrW); i++) begin
         if (tdo_en !== 1'b1) en_ok = 1'b0;
         dout[i] = tdo;
         tick(i == int'(IrW) - 1, op[i]);
      end
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
   endtask

   task automatic load_ir(input logic [IrW-1:0] op, input string tag);
      logic [63:0] dout;
      logic        en_ok;
      sb_push({tag, "_ir_capture"}, 64'h1);
      scan_ir(op, dout, en_ok);
      sb_pop(dout);
      check({tag, "_ir_tdo_en"}, 64'(en_ok), 64'h1);
      check({tag, "_instr"}, 64'(instr), 64'(op));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected $finish before 100000");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] dout;
      logic        en_ok;

      // {op, core_in, pad_in, din, bits, tdo word, pad_out, core_out}
      vecs[0] = '{4'h2, 8'h3C, 8'h00, 64'hF0,  8, 64'h3C,  8'h3C, 8'h00};
      vecs[1] = '{4'h0, 8'h55, 8'hAA, 64'h0F,  8, 64'h55,  8'h0F, 8'hAA};
      vecs[2] = '{4'h3, 8'h12, 8'hC3, 64'h99,  8, 64'hC3,  8'h12, 8'h99};
      vecs[3] = '{4'hF, 8'h66, 8'h77, 64'hA5,  9, 64'h14A, 8'h66, 8'h77};
      vecs[4] = '{4'h5, 8'h01, 8'h02, 64'h0B,  5, 64'h16,  8'h01, 8'h02};
`ifdef JTAG_TAP_IDCODE_EN
      vecs[5] = '{4'h1, 8'h00, 8'h00, 64'h0,  32, 64'(IdVal), 8'h00, 8'h00};
`else
      vecs[5] = '{4'h1, 8'h00, 8'h00, 64'h0B,  5, 64'h16,  8'h00, 8'h00};
`endif

      // Asynchronous reset state.
      rst_n   = 1'b0;
      tms     = 1'b1;
      tdi     = 1'b0;
      core_in = 8'h3C;
      pad_in  = 8'hC3;
      #13;
      check("rst_tlr", 64'(tlr), 64'h1);
      check("rst_tdo_en", 64'(tdo_en), 64'h0);
      check("rst_instr", 64'(instr), 64'(ResetInstr));
      check("rst_pad_out", 64'(pad_out), 64'h3C);
      check("rst_core_out", 64'(core_out), 64'hC3);
      @(negedge tck);
      rst_n = 1'b1;
      @(posedge tck);
      #1;
      tick(1'b0, 1'b0);
      check("rti_tlr", 64'(tlr), 64'h0);

      // First DR scan after reset uses the reset instruction.
`ifdef JTAG_TAP_IDCODE_EN
      sb_push("reset_dr_idcode", 64'(IdVal));
      scan_dr(64'h0, 32, dout, en_ok);
`else
      sb_push("reset_dr_bypass", 64'h2468ACF2);
      scan_dr(64'h12345679, 32, dout, en_ok);
`endif
      sb_pop(dout);
      check("reset_dr_tdo_en", 64'(en_ok), 64'h1);

      // Table of IR/DR scans.
      for (int i = 0; i < 6; i++) begin
         core_in = vecs[i].core;
         pad_in  = vecs[i].pad;
         load_ir(vecs[i].op, $sformatf("vec%0d", i));
         sb_push($sformatf("vec%0d_dr_tdo", i), vecs[i].tdo_w);
         scan_dr(vecs[i].din, vecs[i].n, dout, en_ok);
         sb_pop(dout);
         check($sformatf("vec%0d_pad_out", i), 64'(pad_out), 64'(vecs[i].pad_o));
         check($sformatf("vec%0d_core_out", i), 64'(core_out), 64'(vecs[i].core_o));
      end

      // Preload then EXTEST drives the preloaded value; BYPASS hands pads back to the core.
      core_in = 8'h3C;
      load_ir(4'h2, "preload");
      sb_push("preload_dr_tdo", 64'h3C);
      scan_dr(64'hF0, 8, dout, en_ok);
      sb_pop(dout);
      load_ir(4'h0, "extest");
      check("extest_pad_out", 64'(pad_out), 64'hF0);
      load_ir(4'hF, "bypass");
      check("bypass_pad_out", 64'(pad_out), 64'h3C);
      core_in = 8'h81;
      #1;
      check("bypass_pad_follow", 64'(pad_out), 64'h81);

      // TMS reset from Shift-DR. The path out passes Update-DR: capture 00, shift in
      // 1,1,1 then 0 on the exit edge gives 70, which must survive the trip through TLR.
      core_in = 8'h00;
      load_ir(4'h0, "tmsrst");
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
      for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
      check("tmsrst_tlr", 64'(tlr), 64'h1);
      check("tmsrst_instr", 64'(instr), 64'(ResetInstr));
      check("tmsrst_tdo_en", 64'(tdo_en), 64'h0);
      check("tmsrst_pad_out", 64'(pad_out), 64'h00);
      tick(1'b0, 1'b0);
      load_ir(4'h0, "tmsrst_re");
      check("tmsrst_upd_held", 64'(pad_out), 64'h70);

      // Pause-DR in the middle of a shift must not lose bits.
      core_in = 8'h5A;
      load_ir(4'h2, "pause");
      sb_push("pause_dr_tdo", 64'h5A);
      dout = '0;
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         dout[i] = tdo;
         tick(i == 3, 1'(8'hC3 >> i));
      end
      tick(1'b0, 1'b0);
      check("pause_tdo_en", 64'(tdo_en), 64'h0);
      tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      for (int i = 4; i < 8; i++) begin
         dout[i] = tdo;
         tick(i == 7, 1'(8'hC3 >> i));
      end
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      sb_pop(dout);
      load_ir(4'h0, "pause_ext");
      check("pause_pad_out", 64'(pad_out), 64'hC3);

      // Asynchronous reset in the middle of a DR shift.
      load_ir(4'hF, "arst");
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_tlr", 64'(tlr), 64'h1);
      check("arst_tdo_en", 64'(tdo_en), 64'h0);
      check("arst_instr", 64'(instr), 64'(ResetInstr));
      tms = 1'b1;
      @(negedge tck);
      rst_n = 1'b1;
      tick(1'b1, 1'b0);
      check("arst_stay_tlr", 64'(tlr), 64'h1);

      if (exp_q.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL scoreboard_leftover: got %0d pending, expected 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
